// File: rtl/adc_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module : adc_spi_pkg
// Brief  : State codes and 34-bit frame layout shared by the ADC SPI reader.
// Rev    : 1.0
// ============================================================================
package adc_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3
  } adc_state_e;

  localparam int FRAME_BITS    = 34;
  localparam int CH0_FIRST     = 2;
  localparam int CH1_FIRST     = 18;
  localparam int DATA_BITS_DEF = 14;

  function automatic logic in_window(input logic [5:0] bit_idx, input int first, input int width);
    return (int'(bit_idx) >= first) && (int'(bit_idx) < first + width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sck_divider.sv
`default_nettype none
// ============================================================================
// Module : spi_sck_divider
// Brief  : SCK half-period counter with level output and rise/fall strobes.
// Rev    : 1.0
// ============================================================================
module spi_sck_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_sck_en,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);

  localparam int              CW         = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0]   c_div_last = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          sck_q, sck_d;
  logic          wrap;

  assign wrap = i_en && (cnt_q == c_div_last);

  // phase keeps running while the pin is gated, so the CONV wait is one full SCK period
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (i_clr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (i_en) begin
      if (wrap) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    sck_d = i_sck_en & phase_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sck_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sck_q   <= sck_d;
    end
  end

  assign o_sck  = sck_q;
  assign o_rise = wrap && !phase_q;
  assign o_fall = wrap && phase_q;

endmodule
`default_nettype wire

// File: rtl/adc_spi_reader.sv
`default_nettype none
// ============================================================================
// Module : adc_spi_reader
// Brief  : Pulses AD_CONV, clocks a 34-bit dual-channel ADC frame, presents samples.
//          ADC_FREE_RUN_EN: continuous conversions, IN_START ignored.
// Rev    : 1.0
// ============================================================================
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 IN_CLOCK,
  input  logic                 IN_RESET,
  input  logic                 IN_START,
  input  logic                 IN_SPI_MISO,
  output logic                 OUT_SPI_SCK,
  output logic                 OUT_AD_CONV,
  output logic [DATA_BITS-1:0] OUT_CH0,
  output logic [DATA_BITS-1:0] OUT_CH1,
  output logic                 OUT_VALID,
  output logic                 OUT_BUSY,
  output logic [2:0]           OUT_STATE
);

`ifdef ADC_FREE_RUN_EN
  localparam bit c_free_run = 1'b1;
`else
  localparam bit c_free_run = 1'b0;
`endif
  localparam logic [5:0] c_last_bit = 6'(FRAME_BITS - 1);

  adc_state_e           state_q, state_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] ch0_sr_q, ch0_sr_d, ch1_sr_q, ch1_sr_d;
  logic [DATA_BITS-1:0] ch0_q, ch0_d, ch1_q, ch1_d;
  logic                 ad_conv_q, ad_conv_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 div_en, div_clr, sck_rise, sck_fall, start_go;

  assign start_go = c_free_run | IN_START;

  spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (IN_CLOCK),
    .rst_n    (IN_RESET),
    .i_en     (div_en),
    .i_clr    (div_clr),
    .i_sck_en (state_q == ST_SHIFT),
    .o_sck    (OUT_SPI_SCK),
    .o_rise   (sck_rise),
    .o_fall   (sck_fall)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = '0;
    ch0_sr_d  = ch0_sr_q;
    ch1_sr_d  = ch1_sr_q;
    ch0_d     = ch0_q;
    ch1_d     = ch1_q;
    div_en    = 1'b0;
    div_clr   = 1'b1;
    case (state_q)
      ST_IDLE: if (start_go) state_d = ST_CONV;
      ST_CONV: begin
        div_en  = 1'b1;
        div_clr = 1'b0;
        if (sck_fall) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        div_en    = 1'b1;
        div_clr   = 1'b0;
        bit_cnt_d = bit_cnt_q;
        // MISO is captured on the edge that raises SCK
        if (sck_rise && in_window(bit_cnt_q, CH0_FIRST, DATA_BITS))
          ch0_sr_d = {ch0_sr_q[DATA_BITS-2:0], IN_SPI_MISO};
        if (sck_rise && in_window(bit_cnt_q, CH1_FIRST, DATA_BITS))
          ch1_sr_d = {ch1_sr_q[DATA_BITS-2:0], IN_SPI_MISO};
        if (sck_fall) begin
          if (bit_cnt_q == c_last_bit) begin
            state_d = ST_DONE;
            ch0_d   = ch0_sr_q;
            ch1_d   = ch1_sr_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      ST_DONE: state_d = c_free_run ? ST_CONV : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ad_conv_d = (state_d == ST_CONV);
    busy_d    = (state_d != ST_IDLE);
    valid_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge IN_CLOCK) begin
    if (!IN_RESET) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      ch0_sr_q  <= '0;
      ch1_sr_q  <= '0;
      ch0_q     <= '0;
      ch1_q     <= '0;
      ad_conv_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ch0_sr_q  <= ch0_sr_d;
      ch1_sr_q  <= ch1_sr_d;
      ch0_q     <= ch0_d;
      ch1_q     <= ch1_d;
      ad_conv_q <= ad_conv_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign OUT_AD_CONV = ad_conv_q;
  assign OUT_CH0     = ch0_q;
  assign OUT_CH1     = ch1_q;
  assign OUT_VALID   = valid_q;
  assign OUT_BUSY    = busy_q;
  assign OUT_STATE   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_adc_spi_reader
// Brief  : Directed self-checking bench with an LTC1407A-style MISO model.
// Rev    : 1.0
// ============================================================================
module tb_adc_spi_reader;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        miso;
  logic        sck, conv, valid, busy;
  logic [13:0] ch0, ch1;
  logic [2:0]  state;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] ch0_m = 14'h0;
  logic [13:0] ch1_m = 14'h0;
  logic [33:0] frame_m;
  int          bit_idx = 0;

  int   sck_rises = 0;
  int   conv_cycles = 0;
  int   sck_bad = 0;
  logic sck_prev = 1'b0;

  adc_spi_reader #(.CLK_DIV(CLK_DIV), .DATA_BITS(14)) dut (
    .IN_CLOCK    (clk),
    .IN_RESET    (rst_n),
    .IN_START    (start),
    .IN_SPI_MISO (miso),
    .OUT_SPI_SCK (sck),
    .OUT_AD_CONV (conv),
    .OUT_CH0     (ch0),
    .OUT_CH1     (ch1),
    .OUT_VALID   (valid),
    .OUT_BUSY    (busy),
    .OUT_STATE   (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: ignored bits are driven 1, next bit presented after each SCK fall
  assign frame_m = {2'b11, ch0_m, 2'b11, ch1_m, 2'b11};
  assign miso    = frame_m[33 - bit_idx];

  always @(posedge conv or negedge sck) begin
    if (conv) bit_idx <= 0;
    else if (bit_idx < 33) bit_idx <= bit_idx + 1;
  end

  always @(negedge clk) begin
    sck_prev <= sck;
    if (sck && !sck_prev) sck_rises <= sck_rises + 1;
    if (conv) conv_cycles <= conv_cycles + 1;
    if (sck && state != 3'd2) sck_bad <= sck_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_sck"},   32'(sck),   0);
    chk({tag, "_conv"},  32'(conv),  0);
    chk({tag, "_busy"},  32'(busy),  0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_ch0"},   32'(ch0),   0);
    chk({tag, "_ch1"},   32'(ch1),   0);
  endtask

  // One IN_START pulse; optional second pulse extra_at cycles into the frame
  task automatic run_frame(input string tag, input logic [13:0] c0, input logic [13:0] c1,
                           input int extra_at);
    int t0, r0, cv0, bad0, busy_low;
    ch0_m = c0;
    ch1_m = c1;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc; r0 = sck_rises; cv0 = conv_cycles; bad0 = sck_bad; busy_low = 0;
    @(negedge clk);
    start = 1'b0;
    while (!valid && (cyc - t0) < 300) begin
      if (!busy) busy_low++;
      start = ((cyc - t0) == extra_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_latency"},  32'(cyc - t0), 141);
    chk({tag, "_ch0"},      32'(ch0), 32'(c0));
    chk({tag, "_ch1"},      32'(ch1), 32'(c1));
    chk({tag, "_busy_low"}, 32'(busy_low), 0);
    @(negedge clk);
    chk({tag, "_valid_1cyc"}, 32'(valid), 0);
    chk({tag, "_busy_idle"},  32'(busy), 0);
    chk({tag, "_conv_len"},   32'(conv_cycles - cv0), 4);
    chk({tag, "_sck_rises"},  32'(sck_rises - r0), 34);
    chk({tag, "_sck_idle"},   32'(sck_bad - bad0), 0);
  endtask

  initial begin
    int r0, nv, extra;
    int vt[3];
    vt = '{0, 0, 0};
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

`ifdef ADC_FREE_RUN_EN
    ch0_m = 14'h1ABC;
    ch1_m = 14'h2001;
    nv = 0;
    for (int n = 0; n < 600 && nv < 3; n++) begin
      @(negedge clk);
      if (valid) begin
        vt[nv] = cyc;
        chk("free_ch0", 32'(ch0), 32'(ch0_m));
        chk("free_ch1", 32'(ch1), 32'(ch1_m));
        nv++;
        ch0_m = ch0_m ^ 14'h3FFF;
        ch1_m = ch1_m + 14'h0123;
      end
    end
    chk("free_count", 32'(nv), 3);
    chk("free_gap1", 32'(vt[1] - vt[0]), 141);
    chk("free_gap2", 32'(vt[2] - vt[1]), 141);
`else
    run_frame("nominal", 14'h1ABC, 14'h2001, -1);
    run_frame("pattern", 14'h2AAA, 14'h1555, -1);

    // Busy: extra IN_START at cycle 50 must not queue a frame
    run_frame("busy", 14'h0155, 14'h3E0F, 50);
    extra = 0;
    repeat (160) begin
      @(negedge clk);
      if (valid) extra++;
    end
    chk("busy_no_extra", 32'(extra), 0);
    chk("busy_state_idle", 32'(state), 0);
    run_frame("busy_next", 14'h2AAA, 14'h1555, -1);

    // Reset during SCK bit 10
    ch0_m = 14'h0F0F;
    ch1_m = 14'h30C3;
    @(negedge clk);
    start = 1'b1;
    r0 = sck_rises;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200 && (sck_rises - r0) < 11; n++) @(negedge clk);
    chk("rstmid_reach_bit10", 32'(sck_rises - r0), 11);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("rstmid");
    rst_n = 1'b1;
    run_frame("after_rst", 14'h3FFF, 14'h0000, -1);

    // IN_START held high: back-to-back frames
    ch0_m = 14'h1234;
    ch1_m = 14'h0F0F;
    @(negedge clk);
    start = 1'b1;
    nv = 0;
    for (int n = 0; n < 600 && nv < 3; n++) begin
      @(negedge clk);
      if (valid) begin
        vt[nv] = cyc;
        chk("cont_ch0", 32'(ch0), 32'h1234);
        chk("cont_ch1", 32'(ch1), 32'h0F0F);
        nv++;
      end
    end
    start = 1'b0;
    chk("cont_count", 32'(nv), 3);
    chk("cont_gap1", 32'(vt[1] - vt[0]), 142);
    chk("cont_gap2", 32'(vt[2] - vt[1]), 142);
    repeat (3) @(negedge clk);
    chk("cont_stop_idle", 32'(state), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
